// File: rtl/demux_reg_pkg.sv
// Shared definitions for the demux_reg slice: select encodings (common with
// the 3-to-1 selector mux), channel register states and default widths.
package demux_reg_pkg;

   localparam int NB_INPUT_DEF = 3;
   localparam int NB_CNT_DEF   = 8;

   typedef enum logic [1:0] {
      SEL_CH1  = 2'b00,
      SEL_CH2  = 2'b01,
      SEL_CH3  = 2'b10,
      SEL_DROP = 2'b11
   } dmux_sel_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/demux_reg_if.sv
// Input stream, three output channels and drop counter of demux_reg.
// slave: the demux itself; master: the producer/consumers around it.
interface demux_reg_if #(
   parameter int NB_input = 3,
   parameter int NB_cnt   = 8
) ();

   logic [NB_input:0] e_dmux;
   logic [1:0]        e_dmuxsel;
   logic              e_dmux_valid;
   logic              s_dmux_ready;

   logic [NB_input:0] s_dmux1;
   logic [NB_input:0] s_dmux2;
   logic [NB_input:0] s_dmux3;
   logic              s_dmux1_valid;
   logic              s_dmux2_valid;
   logic              s_dmux3_valid;
   logic              e_dmux1_ready;
   logic              e_dmux2_ready;
   logic              e_dmux3_ready;

   logic [NB_cnt-1:0] s_drop_cnt;

   modport slave (
      input  e_dmux, e_dmuxsel, e_dmux_valid,
      input  e_dmux1_ready, e_dmux2_ready, e_dmux3_ready,
      output s_dmux_ready,
      output s_dmux1, s_dmux2, s_dmux3,
      output s_dmux1_valid, s_dmux2_valid, s_dmux3_valid,
      output s_drop_cnt
   );

   modport master (
      output e_dmux, e_dmuxsel, e_dmux_valid,
      output e_dmux1_ready, e_dmux2_ready, e_dmux3_ready,
      input  s_dmux_ready,
      input  s_dmux1, s_dmux2, s_dmux3,
      input  s_dmux1_valid, s_dmux2_valid, s_dmux3_valid,
      input  s_drop_cnt
   );

endinterface

// File: rtl/demux_reg_slot.sv
// One-entry channel register: holds a word until its consumer takes it.
// Data is kept after drain; only the valid flag (FULL state) clears.
module demux_slot
   import demux_reg_pkg::*;
#(
   parameter int NB_input = NB_INPUT_DEF
) (
   input  logic              e_clk,
   input  logic              e_rst_n,
   input  logic              load,
   input  logic [NB_input:0] d_in,
   input  logic              e_ready,
   output logic [NB_input:0] s_data,
   output logic              s_valid
);

   slot_state_e state, state_nxt;

   // State register.
   always_ff @(posedge e_clk or negedge e_rst_n) begin
      if (!e_rst_n) state <= EMPTY;
      else          state <= state_nxt;
   end

   // Next state: fill on load, empty on drain unless refilled in the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (load) state_nxt = FULL;
         FULL:    if (e_ready && !load) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // Data register: loads only on an accepted word, otherwise holds.
   always_ff @(posedge e_clk or negedge e_rst_n) begin
      if (!e_rst_n)  s_data <= '0;
      else if (load) s_data <= d_in;
   end

   assign s_valid = (state == FULL);

endmodule

// File: rtl/demux_reg.sv
// 1-to-3 registered demultiplexer: routes the input stream to one of three
// channel registers by select; select 11 accepts and counts the word.
module demux_reg
   import demux_reg_pkg::*;
#(
   parameter int NB_input = NB_INPUT_DEF,
   parameter int NB_cnt   = NB_CNT_DEF
) (
   input logic         e_clk,
   input logic         e_rst_n,
   demux_reg_if.slave  dmux
);

   dmux_sel_e         sel;
   logic [2:0]        ch_valid;
   logic [2:0]        ch_ready;
   logic [2:0]        ch_load;
   logic [NB_input:0] ch_data [3];
   logic              in_ready;
   logic              in_xfer;
   logic              drop_xfer;
   logic [NB_cnt-1:0] drop_cnt;

   assign sel      = dmux_sel_e'(dmux.e_dmuxsel);
   assign ch_ready = {dmux.e_dmux3_ready, dmux.e_dmux2_ready, dmux.e_dmux1_ready};

   // Input ready: the selected slot is empty or draining this cycle; drops always accepted.
   always_comb begin
      in_ready = 1'b1;
      case (sel)
         SEL_CH1:  in_ready = !ch_valid[0] || ch_ready[0];
         SEL_CH2:  in_ready = !ch_valid[1] || ch_ready[1];
         SEL_CH3:  in_ready = !ch_valid[2] || ch_ready[2];
         SEL_DROP: in_ready = 1'b1;
         default:  in_ready = 1'b1;
      endcase
   end

   assign in_xfer = dmux.e_dmux_valid && in_ready;

   // Select decode of an accepted word into a slot load or a drop.
   always_comb begin
      ch_load   = '0;
      drop_xfer = 1'b0;
      if (in_xfer) begin
         case (sel)
            SEL_CH1:  ch_load[0] = 1'b1;
            SEL_CH2:  ch_load[1] = 1'b1;
            SEL_CH3:  ch_load[2] = 1'b1;
            SEL_DROP: drop_xfer  = 1'b1;
            default:  drop_xfer  = 1'b0;
         endcase
      end
   end

   // Saturating count of dropped words.
   always_ff @(posedge e_clk or negedge e_rst_n) begin
      if (!e_rst_n)                       drop_cnt <= '0;
      else if (drop_xfer && drop_cnt != '1) drop_cnt <= drop_cnt + NB_cnt'(1);
   end

   for (genvar g = 0; g < 3; g++) begin : g_slot
      demux_slot #(.NB_input(NB_input)) u_slot (
         .e_clk   (e_clk),
         .e_rst_n (e_rst_n),
         .load    (ch_load[g]),
         .d_in    (dmux.e_dmux),
         .e_ready (ch_ready[g]),
         .s_data  (ch_data[g]),
         .s_valid (ch_valid[g])
      );
   end

   assign dmux.s_dmux_ready  = in_ready;
   assign dmux.s_dmux1       = ch_data[0];
   assign dmux.s_dmux2       = ch_data[1];
   assign dmux.s_dmux3       = ch_data[2];
   assign dmux.s_dmux1_valid = ch_valid[0];
   assign dmux.s_dmux2_valid = ch_valid[1];
   assign dmux.s_dmux3_valid = ch_valid[2];
   assign dmux.s_drop_cnt    = drop_cnt;

endmodule

// File: tb/tb_demux_reg.sv
// Scoreboard bench for demux_reg: accepted words are queued per channel and
// checked against the channel register until its consumer takes them.
module tb_demux_reg;
   import demux_reg_pkg::*;

   localparam int NBI     = 3;
   localparam int NBC     = 8;
   localparam int CNT_MAX = (1 << NBC) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   demux_reg_if #(.NB_input(NBI), .NB_cnt(NBC)) bus ();

   demux_reg #(.NB_input(NBI), .NB_cnt(NBC)) dut (
      .e_clk   (clk),
      .e_rst_n (rst_n),
      .dmux    (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [NBI:0] sbq [3][$];
   int unsigned  cnt_m = 0;

   logic [NBI:0] s_d [3];
   logic         s_v [3];
   logic         c_r [3];
   assign s_d[0] = bus.s_dmux1;
   assign s_d[1] = bus.s_dmux2;
   assign s_d[2] = bus.s_dmux3;
   assign s_v[0] = bus.s_dmux1_valid;
   assign s_v[1] = bus.s_dmux2_valid;
   assign s_v[2] = bus.s_dmux3_valid;
   assign c_r[0] = bus.e_dmux1_ready;
   assign c_r[1] = bus.e_dmux2_ready;
   assign c_r[2] = bus.e_dmux3_ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc(input logic v, input logic [1:0] s, input logic [NBI:0] d,
                      input logic [2:0] r);
      @(posedge clk);
      #1;
      bus.e_dmux_valid  = v;
      bus.e_dmuxsel     = s;
      bus.e_dmux        = d;
      bus.e_dmux1_ready = r[0];
      bus.e_dmux2_ready = r[1];
      bus.e_dmux3_ready = r[2];
   endtask

   task automatic chk_all_reset(input string tag);
      chk({tag, "_v1"}, 32'(bus.s_dmux1_valid), 0);
      chk({tag, "_v2"}, 32'(bus.s_dmux2_valid), 0);
      chk({tag, "_v3"}, 32'(bus.s_dmux3_valid), 0);
      chk({tag, "_d2"}, 32'(bus.s_dmux2), 0);
      chk({tag, "_cnt"}, 32'(bus.s_drop_cnt), 0);
   endtask

   // Monitor: sample mid-cycle, compare against the scoreboard, then apply
   // the transfers that the coming rising edge will perform.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            int   sel;
            logic exp_rdy;
            sel = int'(bus.e_dmuxsel);
            if (sel == 3) exp_rdy = 1'b1;
            else          exp_rdy = (sbq[sel].size() == 0) || c_r[sel];
            chk("ready", 32'(bus.s_dmux_ready), 32'(exp_rdy));
            chk("drop_cnt", 32'(bus.s_drop_cnt), cnt_m);
            for (int n = 0; n < 3; n++) begin
               chk($sformatf("valid%0d", n + 1), 32'(s_v[n]), 32'(sbq[n].size() != 0));
               if (sbq[n].size() != 0) begin
                  chk($sformatf("data%0d", n + 1), 32'(s_d[n]), 32'(sbq[n][0]));
                  if (c_r[n]) void'(sbq[n].pop_front());
               end
            end
            if (bus.e_dmux_valid && exp_rdy) begin
               if (sel == 3) begin
                  if (cnt_m != CNT_MAX) cnt_m++;
               end else begin
                  sbq[sel].push_back(bus.e_dmux);
               end
            end
         end
      end
   end

   initial begin
      bus.e_dmux_valid  = 1'b0;
      bus.e_dmuxsel     = 2'b00;
      bus.e_dmux        = '0;
      bus.e_dmux1_ready = 1'b0;
      bus.e_dmux2_ready = 1'b0;
      bus.e_dmux3_ready = 1'b0;

      // Power-on reset, checked before any clock edge.
      #2 rst_n = 1'b0;
      #1 chk_all_reset("por");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single route to ch2, then hold with consumer stalled.
      cyc(1'b1, 2'b01, 4'hA, 3'b000);
      repeat (3) cyc(1'b0, 2'b01, 4'h0, 3'b000);

      // Backpressure on ch1.
      cyc(1'b1, 2'b00, 4'h5, 3'b000);
      cyc(1'b1, 2'b00, 4'h6, 3'b000);
      #2 chk("bp_ready_low", 32'(bus.s_dmux_ready), 0);
      cyc(1'b1, 2'b00, 4'h6, 3'b001);
      #2 chk("bp_ready_high", 32'(bus.s_dmux_ready), 1);
      cyc(1'b0, 2'b00, 4'h0, 3'b000);
      #2 chk("bp_reload", 32'(bus.s_dmux1), 32'h6);

      // Fill ch3, then drain ch1/ch3 while ch2 reloads.
      cyc(1'b1, 2'b10, 4'h7, 3'b000);
      cyc(1'b1, 2'b01, 4'hB, 3'b111);
      cyc(1'b0, 2'b00, 4'h0, 3'b000);
      #2 chk("indep_v1", 32'(bus.s_dmux1_valid), 0);
      chk("indep_v3", 32'(bus.s_dmux3_valid), 0);
      chk("indep_d2", 32'(bus.s_dmux2), 32'hB);

      // Back-to-back stream into ch3 with consumer always ready.
      for (int i = 1; i <= 8; i++) cyc(1'b1, 2'b10, (NBI + 1)'(i), 3'b100);
      cyc(1'b0, 2'b10, 4'h0, 3'b100);

      // Drops: counter saturates, ch2 stays full.
      for (int i = 0; i < 300; i++) cyc(1'b1, 2'b11, (NBI + 1)'($urandom), 3'b000);
      cyc(1'b0, 2'b11, 4'h0, 3'b000);
      #2 chk("drop_sat", 32'(bus.s_drop_cnt), CNT_MAX);
      chk("drop_v2_kept", 32'(bus.s_dmux2_valid), 1);

      // Select/data wiggling without valid has no effect.
      for (int i = 0; i < 10; i++)
         cyc(1'b0, 2'($urandom_range(0, 3)), (NBI + 1)'($urandom), 3'b000);

      // Random traffic.
      for (int i = 0; i < 200; i++)
         cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             (NBI + 1)'($urandom), 3'($urandom_range(0, 7)));

      // Reset mid-operation with ch2 full and a nonzero drop count.
      cyc(1'b1, 2'b11, 4'h0, 3'b000);
      cyc(1'b1, 2'b01, 4'hC, 3'b000);
      cyc(1'b0, 2'b01, 4'h0, 3'b000);
      #1 chk("pre_rst_v2", 32'(bus.s_dmux2_valid), 1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk_all_reset("mid");
      for (int n = 0; n < 3; n++) sbq[n].delete();
      cnt_m = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Traffic after reset release.
      for (int i = 0; i < 50; i++)
         cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             (NBI + 1)'($urandom), 3'($urandom_range(0, 7)));
      repeat (3) cyc(1'b0, 2'b00, 4'h0, 3'b111);

      @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/demux_reg.md
Name: demux_reg

Overview:
- 1-to-3 registered demultiplexer; the distribution counterpart of the team's 3-to-1 selector mux.
- Routes one input word stream to one of three output channels according to a 2-bit select.
- Each channel has a one-entry output register and a valid/ready handshake. Select 2'b11 is an invalid destination: the word is accepted, dropped and counted.
- Sits in front of three independent consumers in the GP01 datapath.

Parameters:
- NB_input, 3, MSB index of data words; data width is NB_input+1 (default 4 bits).
- NB_cnt, 8, width of the saturating drop counter.

Ports:
- e_clk  in  1  clock; all state updates on rising edge
- e_rst_n  in  1  asynchronous active-low reset
- e_dmux  in  NB_input+1  input data word
- e_dmuxsel  in  2  destination: 00->ch1, 01->ch2, 10->ch3, 11->drop
- e_dmux_valid  in  1  input word valid
- s_dmux_ready  out  1  block can accept input this cycle (combinational)
- s_dmux1 / s_dmux2 / s_dmux3  out  NB_input+1 each  channel data registers
- s_dmux1_valid / s_dmux2_valid / s_dmux3_valid  out  1 each  channel register full
- e_dmux1_ready / e_dmux2_ready / e_dmux3_ready  in  1 each  consumer accepts channel word
- s_drop_cnt  out  NB_cnt  count of words accepted with select 11, saturating

Behaviour:
- Reset (async assert on e_rst_n=0, synchronous release): all s_dmuxN=0, all s_dmuxN_valid=0, s_drop_cnt=0.
- Input transfer: occurs when e_dmux_valid && s_dmux_ready.
- Output transfer on channel N: occurs when s_dmuxN_valid && e_dmuxN_ready.
- Ready rule:
  - s_dmux_ready = 1 if e_dmuxsel==11.
  - Otherwise s_dmux_ready = !s_dmuxN_valid || e_dmuxN_ready for the selected channel N.
  - This allows full throughput of one word per cycle with no bubble.
- s_dmux_ready may depend combinationally on e_dmuxsel and e_dmuxN_ready. It must never depend on e_dmux_valid.
- Latency: a word accepted in cycle t appears on s_dmuxN with s_dmuxN_valid=1 in cycle t+1.
- Per-channel register, two states, EMPTY and FULL:
  - EMPTY -> FULL on an input transfer to this channel.
  - FULL -> EMPTY on an output transfer with no simultaneous input transfer.
  - FULL -> FULL on simultaneous output and input transfers; the data register loads the new word.
  - FULL with no output transfer: data holds stable. Valid must not drop without a transfer.
- Non-selected channels are unaffected by input activity and drain independently. All three channels may present output transfers in the same cycle.
- Drop path:
  - An input transfer with select 11 increments s_drop_cnt by 1.
  - The counter saturates at 2^NB_cnt-1; it does not wrap.
  - No channel register changes on a drop.
- Select and data are sampled only on an input transfer. Changes while e_dmux_valid=0 have no effect.
- s_dmuxN data value is don't-care-stable while valid=0: it retains the last loaded word and is not cleared on drain.
- Reset mid-operation: pending channel words are discarded, valids drop immediately (asynchronous), and the counter clears.

Decomposition:
- Shared package/include:
  - Select encodings SEL_CH1=2'b00, SEL_CH2=2'b01, SEL_CH3=2'b10, SEL_DROP=2'b11, shared with the mux.
  - Default NB_input.
- Sub-module demux_slot: one channel register holding data, the valid flag and the load/drain logic.
  - Ports: e_clk, e_rst_n, load, data-in, e_ready, and the data/valid outputs.
  - Instantiated three times.
- Top level holds select decode, the ready mux and the drop counter.

Test Plan:
- Reset check: assert e_rst_n=0 mid-stream with ch2 FULL -> all valids 0 and s_drop_cnt=0 in the same cycle, before any clock edge.
- Single route: sel=01, data=4'hA, valid 1 cycle, e_dmux2_ready=0 -> next cycle s_dmux2=A and s_dmux2_valid=1, other valids 0. Then hold ready low 3 cycles -> data/valid stable.
- Backpressure: ch1 FULL with e_dmux1_ready=0, sel=00, valid=1 -> s_dmux_ready=0 and no overwrite. Raise e_dmux1_ready -> s_dmux_ready=1 same cycle, new word loaded next cycle, valid stays 1.
- Throughput: sel=10, words 1..8 back-to-back with e_dmux3_ready=1 -> s_dmux3 shows 1..8 on consecutive cycles, no bubbles, s_dmux_ready constantly 1.
- Drop/saturation: with NB_cnt=8, send 300 words with sel=11 -> s_drop_cnt=255, channel valids untouched, s_dmux_ready=1 throughout.
- Independence: ch1, ch2 and ch3 all FULL; raise all three consumer readies while sending to ch2 -> ch1/ch3 go EMPTY and ch2 reloads with the new word in the same cycle.
